// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM state types and parity helper for uart_stream
package uart_pkg;
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    function automatic logic data_xor(input logic [7:0] data, input int data_bits);
        logic x;
        x = 1'b0;
        for (int i = 0; i < 8; i++)
            if (i < data_bits) x = x ^ data[i];
        return x;
    endfunction

    // Line-level parity bit: even sends the XOR, odd sends its complement.
    function automatic logic parity_bit(input logic [7:0] data, input int data_bits, input int parity);
        return (parity == PARITY_ODD) ? ~data_xor(data, data_bits) : data_xor(data, data_bits);
    endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - show-ahead synchronous FIFO with full/empty and concurrent push/pop
module uart_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end
endmodule

// File: rtl/uart_stream.sv
// rtl/uart_stream.sv - parametrised full-duplex UART with ready/valid byte streams and RX FIFO
module uart_stream import uart_pkg::*; #(
    parameter int CLKS_PER_BIT  = 434,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       UART_RXD,
    output logic       UART_TXD,
    output logic [7:0] from_uart_data,
    output logic       from_uart_error,
    output logic       from_uart_valid,
    input  logic       from_uart_ready,
    input  logic [7:0] to_uart_data,
    input  logic       to_uart_error,
    input  logic       to_uart_valid,
    output logic       to_uart_ready,
    output logic       rx_overrun
);
    localparam int            CW         = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END    = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE    = 1;
    localparam logic [2:0]    LAST_DATA  = 3'(DATA_BITS - 1);
    localparam bit            HAS_PARITY = (PARITY != PARITY_NONE);
    localparam bit            STOP2      = (STOP_BITS == 2);

    tx_state_t     tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          tx_par;
    logic          tx_second;
    logic          tx_bit_end;

    assign tx_bit_end = (tx_cnt == BIT_END);

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state      <= TX_IDLE;
            tx_cnt        <= '0;
            tx_bit        <= '0;
            tx_shift      <= '0;
            tx_par        <= 1'b0;
            tx_second     <= 1'b0;
            UART_TXD      <= 1'b1;
            to_uart_ready <= 1'b0;
        end else begin
            tx_cnt <= tx_bit_end ? '0 : tx_cnt + CNT_ONE;
            case (tx_state)
                TX_IDLE: begin
                    tx_cnt        <= '0;
                    UART_TXD      <= 1'b1;
                    to_uart_ready <= 1'b1;
                    if (to_uart_valid && to_uart_ready) begin
                        tx_shift      <= to_uart_data;
                        tx_par        <= parity_bit(to_uart_data, DATA_BITS, PARITY)
                                         ^ (HAS_PARITY && to_uart_error);
                        tx_state      <= TX_START;
                        UART_TXD      <= 1'b0;
                        to_uart_ready <= 1'b0;
                    end
                end
                TX_START: if (tx_bit_end) begin
                    tx_state <= TX_DATA;
                    tx_bit   <= '0;
                    UART_TXD <= tx_shift[0];
                end
                TX_DATA: if (tx_bit_end) begin
                    if (tx_bit == LAST_DATA) begin
                        if (HAS_PARITY) begin
                            tx_state <= TX_PARITY;
                            UART_TXD <= tx_par;
                        end else begin
                            tx_state  <= TX_STOP;
                            UART_TXD  <= 1'b1;
                            tx_second <= STOP2;
                        end
                    end else begin
                        tx_bit   <= tx_bit + 3'd1;
                        tx_shift <= tx_shift >> 1;
                        UART_TXD <= tx_shift[1];
                    end
                end
                TX_PARITY: if (tx_bit_end) begin
                    tx_state  <= TX_STOP;
                    UART_TXD  <= 1'b1;
                    tx_second <= STOP2;
                end
                TX_STOP: if (tx_bit_end) begin
                    if (tx_second) begin
                        tx_second <= 1'b0;
                    end else begin
                        tx_state      <= TX_IDLE;
                        to_uart_ready <= 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    logic          rxd_meta;
    logic          rxd_sync;
    rx_state_t     rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_par;
    logic          rx_sample;
    logic          stop_sample;
    logic          rx_error;
    logic          fifo_full;
    logic          fifo_empty;
    logic [8:0]    fifo_head;

    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= UART_RXD;
            rxd_sync <= rxd_meta;
        end
    end

    // After the half-bit start check, a full bit count lands each sample at bit centre.
    assign rx_sample   = (rx_cnt == BIT_END);
    assign stop_sample = (rx_state == RX_STOP) && rx_sample;
    assign rx_error    = !rxd_sync
                         || (HAS_PARITY && (rx_par != parity_bit(rx_shift, DATA_BITS, PARITY)));

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_par     <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= stop_sample && fifo_full;
            rx_cnt     <= rx_sample ? '0 : rx_cnt + CNT_ONE;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (!rxd_sync) rx_state <= RX_START;
                end
                RX_START: if (rx_cnt == HALF_END) begin
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                    rx_shift <= '0;
                    rx_state <= rxd_sync ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_sample) begin
                    rx_shift[rx_bit] <= rxd_sync;
                    if (rx_bit == LAST_DATA) rx_state <= HAS_PARITY ? RX_PARITY : RX_STOP;
                    else                     rx_bit   <= rx_bit + 3'd1;
                end
                RX_PARITY: if (rx_sample) begin
                    rx_par   <= rxd_sync;
                    rx_state <= RX_STOP;
                end
                // A low stop bit (framing error or break) must see the line idle before re-arming.
                RX_STOP: if (rx_sample) rx_state <= rxd_sync ? RX_IDLE : RX_WAIT_HIGH;
                RX_WAIT_HIGH: if (rxd_sync) rx_state <= RX_IDLE;
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    uart_sync_fifo #(
        .WIDTH (9),
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (stop_sample),
        .push_data ({rx_error, rx_shift}),
        .pop       (from_uart_ready),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign from_uart_data  = fifo_head[7:0];
    assign from_uart_error = fifo_head[8];
    assign from_uart_valid = !fifo_empty;
endmodule
